// File: rtl/exu_wb_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exu_wb_arb : N-channel GPR write-back arbiter, registered write port,
//              pending-write scoreboard and one-cycle forwarding path.
// Revision   : 1.0
// ----------------------------------------------------------------------------
module exu_wb_arb #(
  parameter int NCH      = 4,
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ARB_MODE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      ch_vld,
  output logic [NCH-1:0]      ch_rdy,
  input  logic [NCH*AW-1:0]   ch_waddr,
  input  logic [NCH*XLEN-1:0] ch_wdata,
  input  logic                iss_vld,
  input  logic [AW-1:0]       iss_waddr,
  output logic                gpr_wen,
  output logic [AW-1:0]       gpr_waddr,
  output logic [XLEN-1:0]     gpr_wdata,
  output logic                fwd_vld,
  output logic [AW-1:0]       fwd_addr,
  output logic [XLEN-1:0]     fwd_data,
  output logic [(2**AW)-1:0]  gpr_pend
);

  localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NREG = 2**AW;

  logic [PW-1:0]   ptr;
  logic [NCH-1:0]  grant;
  logic            any_grant;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   sel;
  int              j;
  logic [AW-1:0]   gaddr;
  logic [XLEN-1:0] gdata;
  logic            wb_vld;
  logic [NREG-1:0] pend_nxt;

  // Search order: from ptr+1 with wrap in round-robin mode, from 0 otherwise.
  // The wrap is a single conditional subtract so non-power-of-2 NCH works.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    gidx      = '0;
    sel       = '0;
    j         = 0;
    for (int k = 0; k < NCH; k++) begin
      j = (ARB_MODE == 1) ? int'(ptr) + 1 + k : k;
      if (j >= NCH) j = j - NCH;
      sel = PW'(j);
      if (!any_grant && ch_vld[sel]) begin
        any_grant = 1'b1;
        gidx      = sel;
      end
    end
    if (any_grant) grant[gidx] = 1'b1;
  end

  assign ch_rdy = grant;

  always_comb begin
    gaddr = '0;
    gdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        gaddr = gaddr | ch_waddr[i*AW +: AW];
        gdata = gdata | ch_wdata[i*XLEN +: XLEN];
      end
    end
  end

  // A same-cycle issue to the register being retired re-arms it: newer writer.
  always_comb begin
    pend_nxt = gpr_pend;
    if (any_grant) pend_nxt[gaddr] = 1'b0;
    if (iss_vld && (iss_waddr != '0)) pend_nxt[iss_waddr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= PW'(NCH - 1);
      wb_vld    <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      gpr_pend  <= '0;
    end else begin
      wb_vld   <= any_grant;
      gpr_pend <= pend_nxt;
      if (any_grant) begin
        gpr_waddr <= gaddr;
        gpr_wdata <= gdata;
        if (ARB_MODE == 1) ptr <= gidx;
      end
    end
  end

  assign gpr_wen  = wb_vld & (gpr_waddr != '0);
  assign fwd_vld  = gpr_wen;
  assign fwd_addr = gpr_waddr;
  assign fwd_data = gpr_wdata;

endmodule
`default_nettype wire

// File: tb/tb_exu_wb_arb.sv
`default_nettype none
// tb_exu_wb_arb : directed scenarios plus randomized traffic against a
// request-table / modular-search reference model of the write-back arbiter.
module tb_exu_wb_arb;
  localparam int NCH  = 4;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Main instance: round-robin, 4 channels
  logic [NCH-1:0]      ch_vld, ch_rdy;
  logic [NCH*AW-1:0]   ch_waddr;
  logic [NCH*XLEN-1:0] ch_wdata;
  logic                iss_vld;
  logic [AW-1:0]       iss_waddr;
  logic                gpr_wen, fwd_vld;
  logic [AW-1:0]       gpr_waddr, fwd_addr;
  logic [XLEN-1:0]     gpr_wdata, fwd_data;
  logic [31:0]         gpr_pend;

  // Fixed-priority instance, 4 channels
  logic [NCH-1:0]      fp_vld, fp_rdy;
  logic [NCH*AW-1:0]   fp_waddr;
  logic [NCH*XLEN-1:0] fp_wdata;
  logic                fp_wen, fp_fvld;
  logic [AW-1:0]       fp_gaddr, fp_faddr;
  logic [XLEN-1:0]     fp_gdata, fp_fdata;
  logic [31:0]         fp_pend;

  // Round-robin instance, 3 channels (non-power-of-2 wrap)
  logic [2:0]          r3_vld, r3_rdy;
  logic [3*AW-1:0]     r3_waddr;
  logic [3*XLEN-1:0]   r3_wdata;
  logic                r3_wen, r3_fvld;
  logic [AW-1:0]       r3_gaddr, r3_faddr;
  logic [XLEN-1:0]     r3_gdata, r3_fdata;
  logic [31:0]         r3_pend;

  logic                zero_iss  = 1'b0;
  logic [AW-1:0]       zero_addr = '0;

  exu_wb_arb #(.NCH(NCH), .XLEN(XLEN), .AW(AW), .ARB_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .ch_vld(ch_vld), .ch_rdy(ch_rdy),
    .ch_waddr(ch_waddr), .ch_wdata(ch_wdata), .iss_vld(iss_vld), .iss_waddr(iss_waddr),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .fwd_vld(fwd_vld), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .gpr_pend(gpr_pend));

  exu_wb_arb #(.NCH(NCH), .XLEN(XLEN), .AW(AW), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .ch_vld(fp_vld), .ch_rdy(fp_rdy),
    .ch_waddr(fp_waddr), .ch_wdata(fp_wdata), .iss_vld(zero_iss), .iss_waddr(zero_addr),
    .gpr_wen(fp_wen), .gpr_waddr(fp_gaddr), .gpr_wdata(fp_gdata),
    .fwd_vld(fp_fvld), .fwd_addr(fp_faddr), .fwd_data(fp_fdata), .gpr_pend(fp_pend));

  exu_wb_arb #(.NCH(3), .XLEN(XLEN), .AW(AW), .ARB_MODE(1)) dut_r3 (
    .clk(clk), .rst_n(rst_n), .ch_vld(r3_vld), .ch_rdy(r3_rdy),
    .ch_waddr(r3_waddr), .ch_wdata(r3_wdata), .iss_vld(zero_iss), .iss_waddr(zero_addr),
    .gpr_wen(r3_wen), .gpr_waddr(r3_gaddr), .gpr_wdata(r3_gdata),
    .fwd_vld(r3_fvld), .fwd_addr(r3_faddr), .fwd_data(r3_fdata), .gpr_pend(r3_pend));

  task automatic apply_reset();
    ch_vld = '0; ch_waddr = '0; ch_wdata = '0; iss_vld = 1'b0; iss_waddr = '0;
    fp_vld = '0; fp_waddr = '0; fp_wdata = '0;
    r3_vld = '0; r3_waddr = '0; r3_wdata = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (gpr_wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", gpr_wen); end
    total++; if (gpr_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%h exp=0", gpr_waddr); end
    total++; if (gpr_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", gpr_wdata); end
    total++; if (gpr_pend !== 32'd0) begin bad++; $display("FAIL reset_pend got=%h exp=0", gpr_pend); end
    total++; if (fwd_vld !== 1'b0) begin bad++; $display("FAIL reset_fwd_vld got=%b exp=0", fwd_vld); end
    total++; if (ch_rdy !== 4'b0000) begin bad++; $display("FAIL reset_rdy got=%b exp=0000", ch_rdy); end
  endtask

  task automatic test_single();
    ch_vld = 4'b0010;
    ch_waddr[1*AW +: AW] = 5'd3;
    ch_wdata[1*XLEN +: XLEN] = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (ch_rdy !== 4'b0010) begin bad++; $display("FAIL single_rdy got=%b exp=0010", ch_rdy); end
    @(posedge clk); #1 ch_vld = '0;
    total++; if (gpr_wen !== 1'b1) begin bad++; $display("FAIL single_wen got=%b exp=1", gpr_wen); end
    total++; if (gpr_waddr !== 5'd3) begin bad++; $display("FAIL single_waddr got=%h exp=3", gpr_waddr); end
    total++; if (gpr_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%h exp=deadbeef", gpr_wdata); end
    total++; if (fwd_vld !== 1'b1) begin bad++; $display("FAIL single_fwd_vld got=%b exp=1", fwd_vld); end
    total++; if (fwd_addr !== 5'd3 || fwd_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_fwd got=%h/%h exp=3/deadbeef", fwd_addr, fwd_data); end
  endtask

  // Every channel requests; each drops for one cycle right after its grant.
  task automatic test_arb_order();
    int prev4, prev3;
    logic [3:0] exp4;
    logic [2:0] exp3;
    apply_reset();
    prev4 = -1; prev3 = -1;
    for (int c = 0; c < 5; c++) begin
      ch_vld = 4'b1111; r3_vld = 3'b111; fp_vld = 4'b1111;
      if (prev4 >= 0) ch_vld[prev4] = 1'b0;
      if (prev3 >= 0) r3_vld[prev3] = 1'b0;
      exp4 = 4'b0001 << (c % 4);
      exp3 = 3'b001 << (c % 3);
      @(negedge clk);
      total++; if (ch_rdy !== exp4) begin bad++; $display("FAIL rr4_order c=%0d got=%b exp=%b", c, ch_rdy, exp4); end
      total++; if (r3_rdy !== exp3) begin bad++; $display("FAIL rr3_order c=%0d got=%b exp=%b", c, r3_rdy, exp3); end
      total++; if (fp_rdy !== 4'b0001) begin bad++; $display("FAIL fixed_order c=%0d got=%b exp=0001", c, fp_rdy); end
      @(posedge clk); #1;
      prev4 = c % 4; prev3 = c % 3;
    end
    ch_vld = '0; r3_vld = '0; fp_vld = '0;
  endtask

  task automatic test_x0();
    ch_vld = 4'b0001;
    ch_waddr[0 +: AW] = 5'd0;
    ch_wdata[0 +: XLEN] = 32'h5;
    @(negedge clk);
    total++; if (ch_rdy !== 4'b0001) begin bad++; $display("FAIL x0_rdy got=%b exp=0001", ch_rdy); end
    @(posedge clk); #1 ch_vld = '0;
    total++; if (gpr_wen !== 1'b0) begin bad++; $display("FAIL x0_wen got=%b exp=0", gpr_wen); end
    total++; if (fwd_vld !== 1'b0) begin bad++; $display("FAIL x0_fwd_vld got=%b exp=0", fwd_vld); end
    total++; if (gpr_pend[0] !== 1'b0) begin bad++; $display("FAIL x0_pend0 got=%b exp=0", gpr_pend[0]); end
    total++; if (gpr_waddr !== 5'd0 || gpr_wdata !== 32'h5) begin
      bad++; $display("FAIL x0_wbreg got=%h/%h exp=0/5", gpr_waddr, gpr_wdata); end
  endtask

  task automatic test_scoreboard();
    iss_vld = 1'b1; iss_waddr = 5'd7;
    @(posedge clk); #1 iss_vld = 1'b0;
    total++; if (gpr_pend[7] !== 1'b1) begin bad++; $display("FAIL sb_set got=%b exp=1", gpr_pend[7]); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      total++; if (gpr_pend[7] !== 1'b1) begin bad++; $display("FAIL sb_hold c=%0d got=%b exp=1", c, gpr_pend[7]); end
    end
    ch_vld = 4'b0100;
    ch_waddr[2*AW +: AW] = 5'd7;
    ch_wdata[2*XLEN +: XLEN] = 32'h0000_0077;
    @(posedge clk); #1 ch_vld = '0;
    total++; if (gpr_pend[7] !== 1'b0) begin bad++; $display("FAIL sb_clear got=%b exp=0", gpr_pend[7]); end
    total++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd7) begin
      bad++; $display("FAIL sb_wb got=%b/%h exp=1/7", gpr_wen, gpr_waddr); end
  endtask

  task automatic test_set_clear();
    iss_vld = 1'b1; iss_waddr = 5'd9;
    ch_vld = 4'b0001;
    ch_waddr[0 +: AW] = 5'd9;
    ch_wdata[0 +: XLEN] = 32'h99;
    @(posedge clk); #1 iss_vld = 1'b0;
    total++; if (gpr_pend[9] !== 1'b1) begin bad++; $display("FAIL setclr_pend got=%b exp=1", gpr_pend[9]); end
    total++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd9) begin
      bad++; $display("FAIL setclr_wb got=%b/%h exp=1/9", gpr_wen, gpr_waddr); end
    @(posedge clk); #1 ch_vld = '0;
    total++; if (gpr_pend[9] !== 1'b0) begin bad++; $display("FAIL setclr_retire got=%b exp=0", gpr_pend[9]); end
  endtask

  task automatic test_async_reset();
    iss_vld = 1'b1; iss_waddr = 5'd7;
    @(posedge clk); #1;
    iss_waddr = 5'd11;
    ch_vld = 4'b0001;
    ch_waddr[0 +: AW] = 5'd5;
    ch_wdata[0 +: XLEN] = 32'h55;
    @(posedge clk); #1 iss_vld = 1'b0; ch_vld = '0;
    total++; if (gpr_wen !== 1'b1) begin bad++; $display("FAIL ar_pre_wen got=%b exp=1", gpr_wen); end
    total++; if (gpr_pend !== 32'h0000_0880) begin bad++; $display("FAIL ar_pre_pend got=%h exp=00000880", gpr_pend); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (gpr_wen !== 1'b0 || fwd_vld !== 1'b0) begin
      bad++; $display("FAIL ar_wen got=%b/%b exp=0/0", gpr_wen, fwd_vld); end
    total++; if (gpr_pend !== 32'd0) begin bad++; $display("FAIL ar_pend got=%h exp=0", gpr_pend); end
    #1 rst_n = 1'b1;
    ch_vld = 4'b1111;
    for (int i = 0; i < NCH; i++) ch_waddr[i*AW +: AW] = AW'(i + 1);
    #1;
    total++; if (ch_rdy !== 4'b0001) begin bad++; $display("FAIL ar_first_prio got=%b exp=0001", ch_rdy); end
    @(posedge clk); #1 ch_vld = '0;
    total++; if (gpr_waddr !== 5'd1) begin bad++; $display("FAIL ar_after_wb got=%h exp=1", gpr_waddr); end
  endtask

  // Reference model: table of outstanding requests, last granted index,
  // pending bit array and the expected write-back register contents.
  task automatic test_random();
    bit              act[NCH];
    logic [AW-1:0]   raddr[NCH];
    logic [XLEN-1:0] rdata[NCH];
    int              last, g, idx;
    bit   [31:0]     pend;
    bit              wbv, iv;
    logic [AW-1:0]   wba, ia;
    logic [XLEN-1:0] wbd;
    logic [NCH-1:0]  exp_rdy;
    logic            exp_wen;
    apply_reset();
    last = NCH - 1; pend = '0; wbv = 1'b0; wba = '0; wbd = '0;
    for (int i = 0; i < NCH; i++) begin act[i] = 1'b0; raddr[i] = '0; rdata[i] = '0; end
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!act[i] && ($urandom_range(0, 1) == 1)) begin
          act[i] = 1'b1;
          raddr[i] = AW'($urandom_range(0, 31));
          rdata[i] = $urandom;
        end
        ch_vld[i] = act[i];
        ch_waddr[i*AW +: AW] = raddr[i];
        ch_wdata[i*XLEN +: XLEN] = rdata[i];
      end
      iv = ($urandom_range(0, 2) == 0);
      ia = AW'($urandom_range(0, 31));
      iss_vld = iv; iss_waddr = ia;
      g = -1;
      for (int k = 1; k <= NCH; k++) begin
        idx = (last + k) % NCH;
        if (g < 0 && act[idx]) g = idx;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      @(negedge clk);
      total++; if (ch_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, ch_rdy, exp_rdy); end
      @(posedge clk); #1;
      if (g >= 0) begin
        wbv = 1'b1; wba = raddr[g]; wbd = rdata[g];
        act[g] = 1'b0; last = g; pend[wba] = 1'b0;
      end else begin
        wbv = 1'b0;
      end
      if (iv && ia != 0) pend[ia] = 1'b1;
      exp_wen = wbv && (wba != 0);
      total++; if (gpr_wen !== exp_wen || fwd_vld !== exp_wen) begin
        bad++; $display("FAIL rnd_wen c=%0d got=%b/%b exp=%b", c, gpr_wen, fwd_vld, exp_wen); end
      total++; if (gpr_waddr !== wba || gpr_wdata !== wbd) begin
        bad++; $display("FAIL rnd_wb c=%0d got=%h/%h exp=%h/%h", c, gpr_waddr, gpr_wdata, wba, wbd); end
      total++; if (gpr_pend !== pend) begin bad++; $display("FAIL rnd_pend c=%0d got=%h exp=%h", c, gpr_pend, pend); end
    end
    ch_vld = '0; iss_vld = 1'b0;
  endtask

  task automatic test_fixed_random();
    logic [NCH-1:0] v, exp;
    bit found;
    for (int c = 0; c < 40; c++) begin
      v = NCH'($urandom_range(0, 15));
      fp_vld = v;
      exp = '0; found = 1'b0;
      for (int i = 0; i < NCH; i++) if (!found && v[i]) begin exp[i] = 1'b1; found = 1'b1; end
      @(negedge clk);
      total++; if (fp_rdy !== exp) begin bad++; $display("FAIL fixed_rnd c=%0d vld=%b got=%b exp=%b", c, v, fp_rdy, exp); end
      @(posedge clk); #1;
    end
    fp_vld = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_arb_order();
    test_x0();
    test_scoreboard();
    test_set_clear();
    test_async_reset();
    test_random();
    test_fixed_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exu_wb_arb.md
Name: exu_wb_arb

Overview:
- Parametrised N-channel GPR write-back arbiter for the EXU. It generalises the one-hot combinational datapath select into a valid/ready arbiter with a registered write port.
- Lets single-cycle units (LUI, AUIPC, ALU-imm, ALU-reg) and multi-cycle units (load, future mul/div) share the one GPR write port.
- Keeps a per-register pending scoreboard so issue logic can detect RAW/WAW hazards.
- Provides a one-cycle forwarding path from the write-back register.

Parameters:
- NCH, 4, number of write-back channels (2..8).
- XLEN, 32, data width (matches RV_XLEN).
- AW, 5, GPR address width (matches RV_GPR_AW).
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_vld  in  NCH  channel i has a result.
- ch_rdy  out  NCH  channel i granted this cycle.
- ch_waddr  in  NCH*AW  channel i destination; slice i at [i*AW +: AW].
- ch_wdata  in  NCH*XLEN  channel i result; slice i at [i*XLEN +: XLEN].
- iss_vld  in  1  instruction issued that will write a GPR.
- iss_waddr  in  AW  destination of issued instruction.
- gpr_wen  out  1  GPR write enable.
- gpr_waddr  out  AW  GPR write address.
- gpr_wdata  out  XLEN  GPR write data.
- fwd_vld  out  1  forwarding value valid (equals gpr_wen).
- fwd_addr  out  AW  forwarded register.
- fwd_data  out  XLEN  forwarded value.
- gpr_pend  out  2**AW  scoreboard; bit r = write to xr outstanding.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: wb_vld=0, gpr_waddr=0, gpr_wdata=0, gpr_pend=0. The round-robin pointer resets to NCH-1, so channel 0 has first priority.
- Arbitration (combinational):
  - ch_rdy is one-hot or zero, and depends only on ch_vld and the pointer.
  - The GPR port never back-pressures, so exactly one valid channel is granted whenever any ch_vld is high.
  - Handshake: channel i transfers when ch_vld[i] & ch_rdy[i].
  - A channel must hold ch_vld, waddr and wdata stable until granted.
  - ch_rdy may be high only while ch_vld is high.
- ARB_MODE=0: grant the lowest-index valid channel. The pointer is unused.
- ARB_MODE=1: search starts at (ptr+1) mod NCH and wraps. On any grant, ptr <= granted index. With no grant, ptr holds.
- Write-back register, latency 1 cycle from handshake to gpr_wen:
  - Each cycle: wb_vld <= |grant, and wb_addr/wb_data load the granted slice.
  - With no grant, addr and data hold their values; they are don't-care when wb_vld=0.
- gpr_wen = wb_vld & (gpr_waddr != 0). Writes to x0 are absorbed.
- fwd_* mirror gpr_*, with fwd_vld = gpr_wen.
- Scoreboard, updated on the clock edge:
  - Set bit iss_waddr when iss_vld and iss_waddr != 0.
  - Clear bit waddr of the granted channel at the handshake edge, so the bit drops in the same cycle that wb_vld rises.
  - Set and clear of the same register in the same cycle: set wins (a newer writer is outstanding).
  - Bit 0 is always 0.
  - A handshake to a register that is not pending is legal and leaves it clear.
- Reset asserted mid-operation: any in-flight write-back is dropped, gpr_wen goes 0 immediately (async), and the scoreboard is cleared. Nothing is replayed.
- No combinational path from iss_* to ch_rdy.
- Any NCH in 2..8 must synthesise. The round-robin wrap must be correct for non-power-of-2 NCH.

Test Plan:
- Reset, then channel 1 alone: ch_vld=0010, waddr=3, wdata=0xDEADBEEF -> ch_rdy=0010 the same cycle; next cycle gpr_wen=1, gpr_waddr=3, gpr_wdata=0xDEADBEEF, fwd_vld=1.
- ARB_MODE=1, NCH=4, ch_vld=1111 held for 5 cycles (each channel drops vld after its grant, then reasserts) -> grant order 0,1,2,3,0. ARB_MODE=0 under the same stimulus -> channel 0 granted every cycle.
- Write to x0: ch_vld=0001, waddr=0, wdata=0x5 -> next cycle wb_vld internal 1, gpr_wen=0, fwd_vld=0, gpr_pend[0]=0.
- Scoreboard: iss_vld with waddr=7 -> gpr_pend[7]=1 next cycle. Channel 2 returns waddr=7 three cycles later -> pend[7]=0 in the same cycle gpr_wen=1.
- Simultaneous set and clear: iss_vld with waddr=9 in the same cycle as a handshake with waddr=9 -> pend[9] stays 1.
- Async reset mid-stream: rst_n low between edges while gpr_wen=1 and pend=0x0000_0880 -> gpr_wen=0 and pend=0 immediately. After release, channel 0 has first priority.
